// File: rtl/ula_exec.sv
// Multi-cycle execution unit: single-cycle ALU ops and an optional iterative shift-add multiplier.
// Define ULA_EXEC_MUL_EN to build the multiplier (opcode D); otherwise opcode D is illegal.
module ula_exec #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMM_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       codop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [IMM_W-1:0] imm,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             err
);

`ifdef ULA_EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;
  localparam int unsigned CW = $clog2(WIDTH);
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
`endif

  state_e           r_state;
  state_e           w_next;
  logic             w_accept;
  logic [3:0]       r_codop;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IMM_W-1:0] r_imm;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_err;

  logic [WIDTH-1:0] w_imm;
  logic [WIDTH:0]   w_add_ab;
  logic [WIDTH:0]   w_sub_ab;
  logic [WIDTH:0]   w_add_bi;
  logic [WIDTH:0]   w_sub_bi;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_err;

`ifdef ULA_EXEC_MUL_EN
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result_hi;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_mul_last;

  // Product register holds {partial high word, remaining multiplier bits}.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
  assign result_hi  = r_result_hi;
`else
  assign result_hi  = '0;
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign err      = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ULA_EXEC_MUL_EN
          w_next = (codop == 4'hD) ? S_MUL : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next = S_DONE;
`ifdef ULA_EXEC_MUL_EN
      S_MUL:  if (w_mul_last) w_next = S_DONE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_imm    = WIDTH'(r_imm);
  assign w_add_ab = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub_ab = {1'b0, r_a} - {1'b0, r_b};
  assign w_add_bi = {1'b0, r_b} + {1'b0, w_imm};
  assign w_sub_bi = {1'b0, r_b} - {1'b0, w_imm};

  // Bit WIDTH of a widened difference is the borrow.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (r_codop)
      4'h0: begin w_res = w_add_ab[WIDTH-1:0]; w_carry = w_add_ab[WIDTH]; end
      4'h1: begin w_res = w_sub_ab[WIDTH-1:0]; w_carry = w_sub_ab[WIDTH]; end
      4'h2: w_res = (r_b > w_imm) ? WIDTH'(1) : '0;
      4'h3: w_res = r_a & r_b;
      4'h4: w_res = r_a | r_b;
      4'h5: w_res = r_a ^ r_b;
      4'h6: w_res = r_b & w_imm;
      4'h7: w_res = r_b | w_imm;
      4'h8: w_res = r_b ^ w_imm;
      4'h9: begin w_res = w_add_bi[WIDTH-1:0]; w_carry = w_add_bi[WIDTH]; end
      4'hA: begin w_res = w_sub_bi[WIDTH-1:0]; w_carry = w_sub_bi[WIDTH]; end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_codop     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
`ifdef ULA_EXEC_MUL_EN
      r_prod      <= '0;
      r_cnt       <= '0;
      r_result_hi <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_codop <= codop;
        r_a     <= op_a;
        r_b     <= op_b;
        r_imm   <= imm;
`ifdef ULA_EXEC_MUL_EN
        r_prod  <= {{WIDTH{1'b0}}, op_b};
        r_cnt   <= '0;
`endif
      end
      if (r_state == S_EXEC) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_carry  <= w_carry;
        r_err    <= w_err;
`ifdef ULA_EXEC_MUL_EN
        r_result_hi <= '0;
`endif
      end
`ifdef ULA_EXEC_MUL_EN
      if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_result    <= w_prod_nxt[WIDTH-1:0];
          r_result_hi <= w_prod_nxt[2*WIDTH-1:WIDTH];
          r_zero      <= (w_prod_nxt == '0);
          r_carry     <= 1'b0;
          r_err       <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ula_exec.sv
// Directed self-checking bench for ula_exec (WIDTH=16, IMM_W=4); follows ULA_EXEC_MUL_EN if defined.
module tb_ula_exec;
  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  codop;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  imm;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        zero;
  logic        carry;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  ula_exec #(.WIDTH(16), .IMM_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .codop(codop),
    .op_a(op_a), .op_b(op_b), .imm(imm), .ready(ready), .done(done),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  im;
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] im, input logic [15:0] res, input logic [15:0] hi,
                               input logic z, input logic c, input logic e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.im = im; v.res = res; v.hi = hi;
    v.z = z; v.c = c; v.e = e; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Issues one request from IDLE; lat = edge (relative to acceptance) at which done is sampled high, -1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] im, output int lat);
    int k;
    codop = op; op_a = a; op_b = b; imm = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    lat = done ? k + 1 : -1;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] r, input logic [15:0] h,
                          input logic z, input logic c, input logic e);
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".result_hi"}, 32'(result_hi), 32'(h));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".carry"}, 32'(carry), 32'(c));
    chk({tag, ".err"}, 32'(err), 32'(e));
  endtask

  initial begin
    int lat;
    int first_done;
    logic [8:0] dmask;
    logic [8:0] rmask;
    int extra_done;

    start = 1'b0; codop = '0; op_a = '0; op_b = '0; imm = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk_outs("rst", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #19 reset = 1'b1;
    @(posedge clk); #1;

    addv(4'h0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 2);
    addv(4'h0, 16'h1234, 16'h4321, 4'h0, 16'h5555, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h0, 16'h8000, 16'h8000, 4'h0, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 2);
    addv(4'h1, 16'h0005, 16'h0003, 4'h0, 16'h0002, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h1, 16'h0003, 16'h0005, 4'h0, 16'hFFFE, 16'h0, 1'b0, 1'b1, 1'b0, 2);
    addv(4'h2, 16'h0000, 16'h0005, 4'h4, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h2, 16'hFFFF, 16'h0004, 4'h4, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 2);
    addv(4'h2, 16'h0000, 16'h0100, 4'hF, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h3, 16'hF0F0, 16'hFF00, 4'h0, 16'hF000, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h4, 16'h0F00, 16'h00F0, 4'h0, 16'h0FF0, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h5, 16'hA5A5, 16'h0FF0, 4'h0, 16'hAA55, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h5, 16'hFFFF, 16'hFFFF, 4'h0, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 2);
    addv(4'h6, 16'h1111, 16'h00FF, 4'hA, 16'h000A, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h7, 16'h2222, 16'h1230, 4'h5, 16'h1235, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'h8, 16'h3333, 16'h000F, 4'hF, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 2);
    addv(4'h9, 16'h4444, 16'hFFFF, 4'h1, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 2);
    addv(4'h9, 16'h5555, 16'h0010, 4'h3, 16'h0013, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'hA, 16'h6666, 16'h0000, 4'h1, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1'b0, 2);
    addv(4'hA, 16'h7777, 16'h0008, 4'h3, 16'h0005, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'hB, 16'h1234, 16'h5678, 4'h7, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 2);
    addv(4'h0, 16'h0002, 16'h0002, 4'h0, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    addv(4'hC, 16'hFFFF, 16'hFFFF, 4'hF, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 2);
    addv(4'hE, 16'h0001, 16'h0001, 4'h1, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 2);
    addv(4'hF, 16'h8000, 16'h0001, 4'h0, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 2);
`ifdef ULA_EXEC_MUL_EN
    addv(4'hD, 16'h1234, 16'h0100, 4'h0, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0, 17);
    addv(4'hD, 16'hFFFF, 16'hFFFF, 4'h0, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 17);
    addv(4'hD, 16'h0000, 16'h0005, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 17);
    addv(4'hD, 16'h8000, 16'h0002, 4'h0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 17);
    addv(4'hD, 16'h0003, 16'h0005, 4'h0, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
`else
    addv(4'hD, 16'h0002, 16'h0003, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
`endif
    addv(4'h0, 16'h0003, 16'h0004, 4'h0, 16'h0007, 16'h0, 1'b0, 1'b0, 1'b0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].im, lat);
      chk({tag, ".latency"}, 32'(lat), 32'(vecs[i].lat));
      chk_outs(tag, vecs[i].res, vecs[i].hi, vecs[i].z, vecs[i].c, vecs[i].e);
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".ready_after"}, 32'(ready), 32'd1);
      chk({tag, ".held"}, 32'(result), 32'(vecs[i].res));
    end

    // start held high: accept, EXEC, DONE, IDLE, accept ...
    codop = 4'h0; op_a = 16'h0001; op_b = 16'h0001; imm = '0; start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      dmask[k] = done;
      rmask[k] = ready;
    end
    start = 1'b0;
    chk("b2b.done_pattern", 32'(dmask), 32'(9'b010010010));
    chk("b2b.ready_pattern", 32'(rmask), 32'(9'b100100100));
    chk("b2b.result", 32'(result), 32'h2);

`ifdef ULA_EXEC_MUL_EN
    // A start pulse while multiplying must be dropped.
    codop = 4'hD; op_a = 16'h1234; op_b = 16'h0100; imm = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_done = -1;
    extra_done = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin codop = 4'h0; op_a = 16'h0001; op_b = 16'h0001; start = 1'b1; end
      if (k == 5) start = 1'b0;
      if (done && first_done < 0) begin
        first_done = k + 1;
        chk_outs("mulign", 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0);
      end else if (done) begin
        extra_done++;
      end
    end
    chk("mulign.latency", 32'(first_done), 32'd17);
    chk("mulign.extra_done", 32'(extra_done), 32'd0);
    chk("mulign.result_kept", 32'(result), 32'h3400);

    codop = 4'hD; op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
`else
    codop = 4'h0; op_a = 16'h0005; op_b = 16'h0006; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`endif
    chk("abort.busy", 32'(ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort.ready", 32'(ready), 32'd1);
    chk("abort.done", 32'(done), 32'd0);
    chk_outs("abort", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    extra_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    chk("abort.no_done", 32'(extra_done), 32'd0);
    #2 reset = 1'b1;
    run_op(4'h0, 16'h0003, 16'h0004, 4'h0, lat);
    chk("after_abort.latency", 32'(lat), 32'd2);
    chk_outs("after_abort", 16'h0007, 16'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ula_exec.md
ULA_EXEC -- requirements
Module: ula_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data-path width in bits (legal 4..32).
REQ-002 SHALL have parameter IMM_W, default 4, immediate field width (legal 1..WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  request; accepted only when ready=1.
REQ-006 codop  input  4  operation code, sampled at acceptance.
REQ-007 op_a  input  WIDTH  first operand, sampled at acceptance.
REQ-008 op_b  input  WIDTH  second operand, sampled at acceptance.
REQ-009 imm  input  IMM_W  immediate, zero-extended to WIDTH, sampled at acceptance.
REQ-010 ready  output  1  high in IDLE only.
REQ-011 done  output  1  one-cycle pulse when result/flags become valid.
REQ-012 result  output  WIDTH  low result word.
REQ-013 result_hi  output  WIDTH  high product word (MUL), else 0.
REQ-014 zero, carry, err  outputs  1 each  status flags, valid with done, held afterwards.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE for single-cycle ops, and IDLE -> MUL -> DONE for multiply; DONE -> IDLE unconditionally.
REQ-016 start=1 in IDLE SHALL latch codop/op_a/op_b/imm and leave IDLE on the same edge; start outside IDLE SHALL be ignored (no queueing).
REQ-017 Opcodes: 0 a+b; 1 a-b; 2 (b>imm)?1:0 unsigned; 3 a&b; 4 a|b; 5 a^b; 6 b&imm; 7 b|imm; 8 b^imm; 9 b+imm; A b-imm; D unsigned multiply a*b; B,C,E,F illegal.
REQ-018 Single-cycle op accepted at edge N SHALL produce done=1 during cycle after edge N+1 (latency 2 edges, done in DONE state).
REQ-019 MUL SHALL be an iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL; done at edge N+WIDTH+1.
REQ-020 MUL: result = product[WIDTH-1:0], result_hi = product[2*WIDTH-1:WIDTH]; carry=0; zero=1 iff full 2*WIDTH product is 0.
REQ-021 Add ops: carry = carry-out of WIDTH-bit sum; sub ops: carry = borrow (1 iff minuend < subtrahend unsigned); logic/compare ops: carry=0.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-023 zero SHALL be 1 iff result==0 (non-MUL ops); result_hi=0 for non-MUL ops.
REQ-024 Illegal opcode SHALL take single-cycle path with result=0, result_hi=0, zero=1, carry=0, err=1; err=0 for all legal ops.
REQ-025 result, result_hi, flags SHALL update only on the edge entering DONE and hold until next completion.
REQ-026 start held high continuously SHALL yield back-to-back operations with one IDLE cycle between them.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, ready=1, done=0, result=0, result_hi=0, zero=0, carry=0, err=0, clear multiplier accumulator/counter.
REQ-028 reset asserted mid-MUL or mid-EXEC SHALL abort with no done pulse; first edge after release with start=1 SHALL be accepted.

Configuration
REQ-029 Macro ULA_EXEC_MUL_EN defined: opcode D executes multiply per REQ-019/020, MUL state and iterative datapath present.
REQ-030 ULA_EXEC_MUL_EN undefined: no multiplier logic or MUL state; opcode D treated as illegal per REQ-024; result_hi constant 0.

Verification (WIDTH=16, IMM_W=4, macro defined unless noted)
REQ-031 add a=0xFFFF b=0x0001 -> result=0x0000, zero=1, carry=1, err=0, done 2 edges after acceptance.
REQ-032 mul a=0x1234 b=0x0100 -> result=0x3400, result_hi=0x0012, done at edge N+17; start pulsed at N+5 ignored.
REQ-033 codop 2: b=5 imm=4 -> result=1; b=4 imm=4 -> result=0, zero=1; codop A b=0 imm=1 -> result=0xFFFF, carry=1.
REQ-034 mul 0xFFFF*0xFFFF, reset=0 at iteration 8 -> ready=1, outputs 0, no done; then add 3+4 -> result=7.
REQ-035 codop B -> result=0, err=1, zero=1 after 2 edges; next legal op clears err.
REQ-036 macro undefined: codop D a=2 b=3 -> result=0, result_hi=0, err=1, done after 2 edges.
